fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register: consumes the current PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in a 2-entry queue for decode.
- Produces the next-PC value and advance strobe that update the PC register.
- Handles redirects (branch/jump/exception) by flushing in-flight work.

Parameters:
- SIZE, 32, width of PC, addresses and instruction words.
- INC, 4, byte increment from one sequential fetch to the next.
- QDEPTH, 2, decode queue depth; fixed at 2 in this revision, other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  SIZE  current PC register value.
- pc_next  out  SIZE  value for the PC register to load.
- pc_advance  out  1  one-cycle registered strobe; PC register loads pc_next on its rising edge.
- redirect  in  1  one-cycle flush request.
- redirect_pc  in  SIZE  target PC when redirect=1.
- imem_req_valid  out  1  memory request valid.
- imem_req_addr  out  SIZE  request address.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; no backpressure.
- imem_rsp_data  in  SIZE  instruction word.
- id_valid  out  1  decode entry available.
- id_instr  out  SIZE  instruction at queue head.
- id_pc  out  SIZE  PC of queue head.
- id_fault  out  1  head entry is a misalignment fault.
- id_ready  in  1  decode consumes head when id_valid and id_ready.

Behaviour:
- Reset values: all outputs 0, queue empty, state IDLE, no outstanding request.
- States:
  - IDLE: go to REQ when free queue slots > 0.
  - REQ: imem_req_valid=1, imem_req_addr=pc_in held stable until fire (valid & ready). On fire go to WAIT, register pc_next=pc_in+INC, pulse pc_advance the next cycle.
  - WAIT: on imem_rsp_valid, push {addr, data, fault=0}, then go to REQ if a slot is still free, else IDLE.
  - DROP: the outstanding response is discarded when it arrives, then go to REQ.
- Maximum of 1 outstanding request. A request is issued only when queue occupancy is below 2 at REQ entry.
- Fetch latency:
  - Request fire to response is memory-defined (minimum 1 cycle).
  - Response to id_valid is 1 cycle (queue registered).
  - Same-cycle push and pop on a full queue is allowed.
- Redirect (highest priority, any state):
  - Flush queue; id_valid=0 next cycle.
  - pc_next=redirect_pc and pc_advance pulses next cycle.
  - If a request is outstanding (WAIT, or REQ firing in the same cycle), go to DROP; otherwise go to REQ.
  - A redirect during DROP stays in DROP and retargets.
  - A response arriving in the redirect cycle itself is discarded.
- Arithmetic: pc_in+INC is modulo 2^SIZE; 0xFFFFFFFC wraps to 0x00000000 silently.
- imem_req_valid is never withdrawn before fire except by redirect.
- reset mid-transaction: immediate return to reset state; a late memory response is ignored because state is IDLE.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - In REQ with pc_in[1:0]!=0, no memory request is made.
  - An entry {pc_in, instr=0, fault=1} is pushed in that cycle, and pc_advance is not pulsed.
  - FSM goes to IDLE and stays there until redirect.
- Not defined: id_fault tied 0, and addresses are issued unchecked.

Decomposition:
- Package fetch_pkg holds:
  - state enum (IDLE, REQ, WAIT, DROP);
  - the queue entry struct {pc, instr, fault};
  - INC default.
- Sub-module fetch_queue: 2-entry FIFO with push/pop/flush and full/empty, same clk/reset.
- The FSM and PC-update logic stay in fetch_unit.

Test Plan:
- Reset, then pc_in=0x0, ready=1, 1-cycle memory latency, id_ready=1 -> requests at 0x0, 0x4, 0x8 in order. pc_advance pulses once per fire with pc_next=0x4, 0x8, 0xC. id_pc/id_instr match.
- id_ready=0 with 3 sequential fetches available -> exactly 2 entries queued, imem_req_valid stays 0 while full. Raising id_ready resumes fetch at 0x8.
- Redirect to 0x100 while in WAIT for 0x4 -> queue flushed, the 0x4 response is dropped. pc_next=0x100 pulses, next request address is 0x100.
- imem_req_ready=0 for 5 cycles in REQ -> valid and address held constant, no pc_advance until fire.
- pc_in=0xFFFFFFFC fetch -> pc_next=0x00000000.
- With FETCH_ALIGN_CHECK_EN, pc_in=0x102 -> no request, id_fault=1 with id_pc=0x102. Stalls until redirect to 0x200, then fetches 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction-fetch stage
package fetch_pkg;

    localparam int SIZE_DEF = 32;
    localparam int INC_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [SIZE_DEF-1:0] pc;
        logic [SIZE_DEF-1:0] instr;
        logic                fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry decode queue with push/pop/flush
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // A pop frees the head slot in the same cycle, so a full queue can accept a push.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with PC update and redirect flush
// Optional misaligned-PC fault entries: FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int INC    = INC_DEF,
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] pc_in,
    output logic [SIZE-1:0] pc_next,
    output logic            pc_advance,
    input  logic            redirect,
    input  logic [SIZE-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [SIZE-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [SIZE-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [SIZE-1:0] id_instr,
    output logic [SIZE-1:0] id_pc,
    output logic            id_fault,
    input  logic            id_ready
);

    localparam logic [1:0] QMAX = 2'(QDEPTH);

    fetch_state_t    state_q, state_d;
    logic [SIZE-1:0] pc_next_q, pc_next_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic            pc_advance_q, pc_advance_d;
    logic            stall_q, stall_d;

    logic            req_slot, misalign, fire, rsp_push, align_push;
    logic            push, pop, full, empty, outstanding;
    logic [1:0]      count, count_after;
    fetch_entry_t    push_entry, head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = (pc_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // pc_in is stale while pc_advance is high; hold off requesting until it has loaded.
    assign req_slot       = (state_q == ST_REQ) && !pc_advance_q;
    assign imem_req_valid = req_slot && !misalign;
    assign imem_req_addr  = imem_req_valid ? pc_in : '0;
    assign fire           = imem_req_valid && imem_req_ready;
    assign rsp_push       = (state_q == ST_WAIT) && imem_rsp_valid;
    assign align_push     = req_slot && misalign;
    assign push           = (rsp_push || align_push) && !redirect;
    assign pop            = !empty && id_ready;
    assign count_after    = count + {1'b0, push} - {1'b0, pop};
    assign outstanding    = fire || (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem_rsp_valid);
    assign push_entry     = align_push ? '{pc: pc_in, instr: '0, fault: 1'b1}
                                       : '{pc: addr_q, instr: imem_rsp_data, fault: 1'b0};

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_comb begin
        state_d      = state_q;
        pc_next_d    = pc_next_q;
        pc_advance_d = 1'b0;
        addr_d       = addr_q;
        stall_d      = stall_q;
        if (redirect) begin
            pc_next_d    = redirect_pc;
            pc_advance_d = 1'b1;
            stall_d      = 1'b0;
            state_d      = outstanding ? ST_DROP : ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: if (!full && !stall_q) state_d = ST_REQ;
                ST_REQ: begin
                    if (fire) begin
                        state_d      = ST_WAIT;
                        addr_d       = pc_in;
                        pc_next_d    = pc_in + SIZE'(INC);
                        pc_advance_d = 1'b1;
                    end else if (align_push) begin
                        state_d = ST_IDLE;
                        stall_d = 1'b1;
                    end
                end
                ST_WAIT: if (imem_rsp_valid) state_d = (count_after < QMAX) ? ST_REQ : ST_IDLE;
                ST_DROP: if (imem_rsp_valid) state_d = ST_REQ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_next_q    <= '0;
            pc_advance_q <= 1'b0;
            addr_q       <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_next_q    <= pc_next_d;
            pc_advance_q <= pc_advance_d;
            addr_q       <= addr_d;
            stall_q      <= stall_d;
        end
    end

    assign pc_next    = pc_next_q;
    assign pc_advance = pc_advance_q;
    assign id_valid   = !empty;
    assign id_instr   = head.instr;
    assign id_pc      = head.pc;
    assign id_fault   = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a stream-level model
module tb_fetch_unit;

    logic        clk, reset;
    logic [31:0] pc_in, pc_next, redirect_pc, imem_req_addr, imem_rsp_data, id_instr, id_pc;
    logic        pc_advance, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        id_valid, id_fault, id_ready;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_next        (pc_next),
        .pc_advance     (pc_advance),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_fault       (id_fault),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec, n_bad;
    logic [31:0] pc_reg, exp_fetch, exp_id, exp_adv_pc, prev_addr, mem_addr;
    logic [31:0] last_fire, last_pop_pc, last_adv_pc, drv_redirect_pc;
    bit          exp_adv, exp_flush, prev_stall, mem_pend;
    bit          drv_id_ready, drv_req_ready, drv_redirect;
    int          mem_cnt, lat_min, lat_max, fires, pops;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // One cycle: drive at negedge, sample after settling, advance the model, wait for next negedge.
    task automatic step();
        bit          fire, pop, e_fault;
        logic [31:0] e_instr, f_exp;
        pc_in          = pc_reg;
        id_ready       = drv_id_ready;
        imem_req_ready = drv_req_ready;
        redirect       = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        if (mem_pend && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_of(mem_addr);
            mem_pend       = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        check("pc_advance", 32'(pc_advance), 32'(exp_adv));
        if (exp_adv) check("pc_next", pc_next, exp_adv_pc);
        if (pc_advance) last_adv_pc = pc_next;
        if (exp_flush) check("flush_id_valid", 32'(id_valid), 32'd0);
        if (prev_stall) begin
            check("hold_valid", 32'(imem_req_valid), 32'd1);
            check("hold_addr", imem_req_addr, prev_addr);
        end
        fire = imem_req_valid && imem_req_ready;
        pop  = id_valid && id_ready;
        if (pop) begin
            e_fault = 1'b0;
            e_instr = data_of(exp_id);
`ifdef FETCH_ALIGN_CHECK_EN
            if (exp_id[1:0] != 2'b00) begin
                e_fault = 1'b1;
                e_instr = 32'd0;
            end
`endif
            check("id_pc", id_pc, exp_id);
            check("id_instr", id_instr, e_instr);
            check("id_fault", 32'(id_fault), 32'(e_fault));
            last_pop_pc = id_pc;
            pops++;
            exp_id += 32'd4;
        end
        f_exp = exp_fetch;
        if (fire) begin
            check("one_outstanding", 32'(mem_pend), 32'd0);
            check("req_addr", imem_req_addr, exp_fetch);
            last_fire = imem_req_addr;
            fires++;
            exp_fetch += 32'd4;
        end
        exp_adv    = fire || drv_redirect;
        exp_adv_pc = drv_redirect ? drv_redirect_pc : f_exp + 32'd4;
        exp_flush  = drv_redirect;
        prev_stall = imem_req_valid && !imem_req_ready && !drv_redirect;
        prev_addr  = imem_req_addr;
        if (drv_redirect) begin
            exp_fetch = drv_redirect_pc;
            exp_id    = drv_redirect_pc;
        end
        if (mem_pend) mem_cnt--;
        if (fire) begin
            mem_pend = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
        end
        if (pc_advance) pc_reg = pc_next;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit keep_pend);
        reset          = 1'b1;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        pc_in          = $urandom;
        repeat (2) @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        check("rst_pc_advance", 32'(pc_advance), 32'd0);
        check("rst_pc_next", pc_next, 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_fault", 32'(id_fault), 32'd0);
        pc_reg = 0; exp_fetch = 0; exp_id = 0;
        exp_adv = 0; exp_flush = 0; prev_stall = 0; drv_redirect = 0;
        if (keep_pend) mem_cnt = 0;
        else mem_pend = 1'b0;
        pc_in = 32'd0;
        reset = 1'b0;
    endtask

    task automatic wait_fire(input string tag, input int budget);
        int f0 = fires;
        int n = 0;
        while (fires == f0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_fire_timeout"}, 32'(fires > f0), 32'd1);
    endtask

    task automatic wait_pop(input string tag, input int budget);
        int p0 = pops;
        int n = 0;
        while (pops == p0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_pop_timeout"}, 32'(pops > p0), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        drv_redirect    = 1'b1;
        drv_redirect_pc = target;
        step();
        drv_redirect    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_bad = 0; fires = 0; pops = 0;
        mem_pend = 0; mem_cnt = 0; mem_addr = 0;
        reset = 1'b1; pc_in = 0; redirect_pc = 0; imem_rsp_data = 0;
        drv_redirect = 0; drv_redirect_pc = 0;

        // Sequential fetch with 1-cycle memory
        drv_id_ready = 1; drv_req_ready = 1; lat_min = 1; lat_max = 1;
        do_reset(0);
        wait_fire("t1a", 20); check("t1_addr0", last_fire, 32'h0);
        wait_fire("t1b", 20); check("t1_addr1", last_fire, 32'h4);
        wait_fire("t1c", 20); check("t1_addr2", last_fire, 32'h8);
        step(); check("t1_pc_next", last_adv_pc, 32'hC);

        // Decode stalled: queue fills to 2 and fetch stops
        drv_id_ready = 0;
        do_reset(0);
        fires = 0;
        repeat (20) step();
        check("t2_fires", 32'(fires), 32'd2);
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_id_valid", 32'(id_valid), 32'd1);
        check("t2_id_pc", id_pc, 32'h0);
        drv_id_ready = 1;
        wait_fire("t2", 20); check("t2_resume_addr", last_fire, 32'h8);

        // Redirect while waiting on 0x4
        drv_id_ready = 0; lat_min = 3; lat_max = 3;
        do_reset(0);
        wait_fire("t3a", 20);
        wait_fire("t3b", 20); check("t3_wait_addr", last_fire, 32'h4);
        do_redirect(32'h100);
        check("t3_flush", 32'(id_valid), 32'd0);
        check("t3_adv", 32'(pc_advance), 32'd1);
        check("t3_pc_next", pc_next, 32'h100);
        drv_id_ready = 1;
        wait_fire("t3c", 20); check("t3_new_addr", last_fire, 32'h100);
        wait_pop("t3", 20); check("t3_pop_pc", last_pop_pc, 32'h100);

        // Memory not ready for 5 cycles
        drv_req_ready = 0; lat_min = 1; lat_max = 1;
        do_reset(0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t4_valid", 32'(imem_req_valid), 32'd1);
            check("t4_addr", imem_req_addr, 32'h0);
            check("t4_no_adv", 32'(pc_advance), 32'd0);
            step();
        end
        drv_req_ready = 1;
        wait_fire("t4", 5); check("t4_fire_addr", last_fire, 32'h0);

        // Address wrap
        do_redirect(32'hFFFF_FFFC);
        wait_fire("t5a", 20); check("t5_addr", last_fire, 32'hFFFF_FFFC);
        step(); check("t5_wrap", last_adv_pc, 32'h0);
        wait_fire("t5b", 20); check("t5_wrap_addr", last_fire, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC produces a fault entry and stalls until redirect
        do_redirect(32'h102);
        drv_id_ready = 0;
        repeat (3) step();
        begin
            int f0 = fires;
            repeat (8) step();
            check("t6_no_fire", 32'(fires), 32'(f0));
        end
        check("t6_id_valid", 32'(id_valid), 32'd1);
        check("t6_id_fault", 32'(id_fault), 32'd1);
        check("t6_id_pc", id_pc, 32'h102);
        check("t6_req_valid", 32'(imem_req_valid), 32'd0);
        drv_id_ready = 1;
        do_redirect(32'h200);
        wait_fire("t6", 20); check("t6_addr", last_fire, 32'h200);
`endif

        // Reset while a response is outstanding; the late response must be ignored
        lat_min = 3; lat_max = 3; drv_id_ready = 1;
        do_reset(0);
        wait_fire("t7a", 20);
        wait_fire("t7b", 20);
        step();
        do_reset(1);
        wait_pop("t7", 30); check("t7_pop_pc", last_pop_pc, 32'h0);

        // Randomized traffic
        lat_min = 1; lat_max = 4;
        do_reset(0);
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            drv_id_ready  = ($urandom_range(9, 0) < 7);
            drv_req_ready = ($urandom_range(9, 0) < 7);
            if ($urandom_range(31, 0) == 0) begin
                drv_redirect    = 1'b1;
                drv_redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                              : ($urandom & 32'hFFFF_FFFC);
            end
            step();
            drv_redirect = 1'b0;
        end
        check("rand_progress", 32'(pops > 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
